programmable_counter_bank: RTL and testbench
============================================

PROGRAMMABLE_COUNTER_BANK -- requirements
Module: programmable_counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each channel counter, limit and load value.
REQ-002 SHALL have parameter NCH, default 4: number of independent counter channels.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port clr  input  NCH: per-channel synchronous clear.
REQ-006 SHALL have port en  input  NCH: per-channel count enable.
REQ-007 SHALL have port dir  input  NCH: per-channel direction, 0 = up, 1 = down.
REQ-008 SHALL have port oneshot  input  NCH: per-channel mode, 0 = periodic, 1 = one-shot.
REQ-009 SHALL have port load  input  NCH: per-channel synchronous load strobe.
REQ-010 SHALL have port load_val  input  NCH*WIDTH: channel i value at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port limit  input  NCH*WIDTH: channel i terminal value, same packing.
REQ-012 SHALL have port q  output  NCH*WIDTH: registered channel counts, same packing.
REQ-013 SHALL have port tc  output  NCH: registered one-cycle terminal-count pulse per channel.
REQ-014 SHALL have port done  output  NCH: sticky one-shot completion flag per channel.
REQ-015 SHALL have port any_tc  output  1: registered OR of all channel tc strobes.

Function
REQ-016 Each channel SHALL apply per-edge priority clr > load > en > hold.
REQ-017 clr SHALL set q = 0, done = 0 and tc = 0 on the next edge.
REQ-018 load SHALL set q = load_val and done = 0 on the next edge; tc SHALL be 0 that cycle.
REQ-019 Up, periodic, en = 1: q >= limit -> q <= 0 and tc <= 1; otherwise q <= q + 1 and tc <= 0.
REQ-020 Down, periodic, en = 1: q == 0 -> q <= limit and tc <= 1; otherwise q <= q - 1 and tc <= 0.
REQ-021 Up and q > limit (limit lowered mid-count) SHALL wrap to 0 on the next enabled edge with tc asserted.
REQ-022 Down and q > limit SHALL keep decrementing to 0 with no special action.
REQ-023 limit == 0 and en held high SHALL keep q at 0 in either direction and assert tc every cycle.
REQ-024 One-shot at the terminal condition SHALL: pulse tc once; set done; hold q (up: hold at limit, no wrap to 0; down: hold at 0).
REQ-025 While done = 1, en SHALL be ignored until clr or load.
REQ-026 en = 0 SHALL hold q and drive tc = 0.
REQ-027 tc SHALL be high for exactly one cycle, in the cycle after the terminal edge.
REQ-028 A change on dir or oneshot SHALL take effect at the next enabled edge, with no extra-cycle penalty.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH; at limit = 2^WIDTH-1 up-counting SHALL wrap cleanly.
REQ-030 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-031 any_tc SHALL be registered and coincident with the tc pulses it reflects.

Reset
REQ-032 reset_n low SHALL immediately force q = 0, tc = 0, done = 0 and any_tc = 0, independent of clk.
REQ-033 Deassertion of reset_n SHALL be synchronised externally; the first edge after release SHALL obey REQ-016.
REQ-034 Reset mid-count SHALL discard all state, including a pending one-shot done.

Structure
REQ-035 A shared package counter_pkg SHALL define DIR_UP/DIR_DOWN, MODE_PERIODIC/MODE_ONESHOT and default WIDTH/NCH constants.
REQ-036 The block SHALL instantiate NCH copies of sub-module counter_channel, one scalar channel each, via a generate loop.
REQ-037 The top level SHALL contain only packing/unpacking and the any_tc register.

Verification (WIDTH=8, NCH=4)
REQ-038 ch0 up, periodic, limit=3, en=1 for 10 cycles -> q 0,1,2,3,0,1,2,3,0,1; tc high in the cycles q=0 after wrap.
REQ-039 ch1 down, one-shot, load_val=2 then en=1 -> q 2,1,0,0,0; tc exactly once; done=1 and stays 1; a later load clears done.
REQ-040 ch2 up at q=9, limit lowered to 5 -> next enabled edge q=0 with tc=1.
REQ-041 clr, load and en all high on ch3 -> q=0; load alone with load_val=7 -> q=7, tc=0.
REQ-042 reset_n pulsed low mid-count between clock edges -> all q, tc, done and any_tc zero immediately; counting resumes from 0.
REQ-043 limit=255 up on all channels with staggered tc -> any_tc equals the OR of tc every cycle.

Source files
------------

// File: rtl/programmable_counter_bank_pkg.sv
// rtl/programmable_counter_bank_pkg.sv - shared constants and mode encodings for the counter bank
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NCH   = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

endpackage

// File: rtl/programmable_counter_bank_if.sv
// rtl/programmable_counter_bank_if.sv - control/status bundle of the counter bank
interface programmable_counter_bank_if #(
  parameter int WIDTH = counter_pkg::DEFAULT_WIDTH,
  parameter int NCH   = counter_pkg::DEFAULT_NCH
);

  logic [NCH-1:0]       clr;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       dir;
  logic [NCH-1:0]       oneshot;
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] load_val;
  logic [NCH*WIDTH-1:0] limit;
  logic [NCH*WIDTH-1:0] q;
  logic [NCH-1:0]       tc;
  logic [NCH-1:0]       done;
  logic                 any_tc;

  // Controller side: drives controls, observes counts and strobes.
  modport master (
    output clr, en, dir, oneshot, load, load_val, limit,
    input  q, tc, done, any_tc
  );

  // Counter bank side.
  modport slave (
    input  clr, en, dir, oneshot, load, load_val, limit,
    output q, tc, done, any_tc
  );

endinterface

// File: rtl/programmable_counter_bank_channel.sv
// rtl/programmable_counter_bank_channel.sv - one programmable up/down periodic/one-shot counter
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             tc_next
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_d;
  logic             done_d;
  logic             tc_d;

  // Next state: clr beats load beats en; a finished one-shot ignores en.
  always_comb begin
    q_d    = q;
    done_d = done;
    tc_d   = 1'b0;
    if (clr) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = load_val;
      done_d = 1'b0;
    end else if (en && !done) begin
      if (dir_e'(dir) == DIR_UP) begin
        // >= so a limit lowered below the current count still wraps.
        if (q >= limit) begin
          tc_d = 1'b1;
          if (mode_e'(oneshot) == MODE_ONESHOT) begin
            done_d = 1'b1;
          end else begin
            q_d = '0;
          end
        end else begin
          q_d = q + ONE;
        end
      end else begin
        if (q == '0) begin
          tc_d = 1'b1;
          if (mode_e'(oneshot) == MODE_ONESHOT) begin
            done_d = 1'b1;
          end else begin
            q_d = limit;
          end
        end else begin
          q_d = q - ONE;
        end
      end
    end
  end

  // tc_next lets the top register any_tc on the same edge as tc.
  assign tc_next = tc_d;

  // Channel state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= '0;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_d;
      tc   <= tc_d;
      done <= done_d;
    end
  end

endmodule

// File: rtl/programmable_counter_bank.sv
// rtl/programmable_counter_bank.sv - bank of NCH independent programmable counters
module programmable_counter_bank
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NCH   = DEFAULT_NCH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       dir,
  input  logic [NCH-1:0]       oneshot,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic [NCH*WIDTH-1:0] limit,
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       done,
  output logic                 any_tc
);

  logic [NCH-1:0] tc_next;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr[i]),
      .en       (en[i]),
      .dir      (dir[i]),
      .oneshot  (oneshot[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .limit    (limit[i*WIDTH +: WIDTH]),
      .q        (q[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .done     (done[i]),
      .tc_next  (tc_next[i])
    );
  end

  // any_tc built from next-state strobes so it lands with the tc pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_tc <= 1'b0;
    end else begin
      any_tc <= |tc_next;
    end
  end

endmodule

// File: tb/tb_programmable_counter_bank.sv
// tb/tb_programmable_counter_bank.sv - scoreboard bench for programmable_counter_bank
module tb_programmable_counter_bank;
  import counter_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  programmable_counter_bank_if #(.WIDTH(W), .NCH(N)) bus ();

  programmable_counter_bank #(.WIDTH(W), .NCH(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (bus.clr),
    .en       (bus.en),
    .dir      (bus.dir),
    .oneshot  (bus.oneshot),
    .load     (bus.load),
    .load_val (bus.load_val),
    .limit    (bus.limit),
    .q        (bus.q),
    .tc       (bus.tc),
    .done     (bus.done),
    .any_tc   (bus.any_tc)
  );

  typedef struct packed {
    logic [N*W-1:0] q;
    logic [N-1:0]   tc;
    logic [N-1:0]   done;
    logic           any;
  } exp_t;

  exp_t           sb[$];
  logic [W-1:0]   m_q[N];
  logic [N-1:0]   m_tc;
  logic [N-1:0]   m_done;
  int             vectors = 0;
  int             miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_q[i] = '0;
    m_tc   = '0;
    m_done = '0;
  endtask

  // Reference behaviour for one rising edge given the inputs now on the bus.
  task automatic predict();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] lim;
      logic         term;
      lim     = bus.limit[i*W +: W];
      m_tc[i] = 1'b0;
      if (bus.clr[i]) begin
        m_q[i]    = '0;
        m_done[i] = 1'b0;
      end else if (bus.load[i]) begin
        m_q[i]    = bus.load_val[i*W +: W];
        m_done[i] = 1'b0;
      end else if (bus.en[i] && !m_done[i]) begin
        term = bus.dir[i] ? (m_q[i] == '0) : (m_q[i] >= lim);
        if (term) begin
          m_tc[i] = 1'b1;
          if (bus.oneshot[i]) m_done[i] = 1'b1;
          else m_q[i] = bus.dir[i] ? lim : '0;
        end else begin
          m_q[i] = bus.dir[i] ? W'(m_q[i] - W'(1)) : W'(m_q[i] + W'(1));
        end
      end
      e.q[i*W +: W] = m_q[i];
    end
    e.tc   = m_tc;
    e.done = m_done;
    e.any  = |m_tc;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_val("q", 64'(bus.q), 64'(e.q));
      check_val("tc", 64'(bus.tc), 64'(e.tc));
      check_val("done", 64'(bus.done), 64'(e.done));
      check_val("any_tc", 64'(bus.any_tc), 64'(e.any));
    end
  endtask

  task automatic idle();
    bus.clr = '0; bus.en = '0; bus.dir = '0; bus.oneshot = '0; bus.load = '0;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] lim, input logic [W-1:0] lv);
    bus.limit[i*W +: W]    = lim;
    bus.load_val[i*W +: W] = lv;
  endtask

  int seq38[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
  int tc_count;

  initial begin
    idle();
    bus.limit = '0;
    bus.load_val = '0;
    model_reset();

    // Reset state
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_q", 64'(bus.q), 64'd0);
    check_val("rst_tc", 64'(bus.tc), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_any", 64'(bus.any_tc), 64'd0);
    reset_n = 1'b1;

    // ch0 up periodic, limit 3
    set_ch(0, 8'd3, 8'd0);
    bus.en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("r38_q", 64'(bus.q[7:0]), 64'(seq38[k]));
      check_val("r38_tc", 64'(bus.tc[0]), 64'(seq38[k] == 0 && k > 0));
    end
    idle();

    // ch1 down one-shot from 2
    set_ch(1, 8'd5, 8'd2);
    bus.dir[1] = 1'b1; bus.oneshot[1] = 1'b1; bus.load[1] = 1'b1;
    step();
    check_val("r39_load", 64'(bus.q[15:8]), 64'd2);
    bus.load[1] = 1'b0; bus.en[1] = 1'b1;
    tc_count = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.tc[1]) tc_count++;
    end
    check_val("r39_q_hold", 64'(bus.q[15:8]), 64'd0);
    check_val("r39_tc_once", 64'(tc_count), 64'd1);
    check_val("r39_done", 64'(bus.done[1]), 64'd1);
    bus.en[1] = 1'b0; bus.load[1] = 1'b1;
    step();
    check_val("r39_done_clr", 64'(bus.done[1]), 64'd0);
    idle();

    // ch2 limit lowered below count
    set_ch(2, 8'd20, 8'd9);
    bus.load[2] = 1'b1;
    step();
    bus.load[2] = 1'b0; bus.en[2] = 1'b1;
    set_ch(2, 8'd5, 8'd9);
    step();
    check_val("r40_q", 64'(bus.q[23:16]), 64'd0);
    check_val("r40_tc", 64'(bus.tc[2]), 64'd1);
    idle();

    // ch3 priority
    set_ch(3, 8'd50, 8'd7);
    bus.clr[3] = 1'b1; bus.load[3] = 1'b1; bus.en[3] = 1'b1;
    step();
    check_val("r41_clr", 64'(bus.q[31:24]), 64'd0);
    bus.clr[3] = 1'b0; bus.en[3] = 1'b0;
    step();
    check_val("r41_load", 64'(bus.q[31:24]), 64'd7);
    check_val("r41_tc", 64'(bus.tc[3]), 64'd0);
    idle();

    // limit 0, both directions, tc every cycle
    set_ch(0, 8'd0, 8'd0); set_ch(1, 8'd0, 8'd0);
    bus.clr[1:0] = 2'b11;
    step();
    bus.clr = '0; bus.en[1:0] = 2'b11; bus.dir[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("lim0_tc", 64'(bus.tc[1:0]), 64'd3);
    end
    idle();

    // full-range wrap on all channels, staggered tc
    for (int i = 0; i < N; i++) set_ch(i, 8'd255, 8'(250 + i));
    bus.load = '1;
    step();
    bus.load = '0; bus.en = '1;
    for (int k = 0; k < 10; k++) step();
    check_val("r29_wrap", 64'(bus.q[7:0]), 64'd4);
    idle();

    // async reset between edges mid-count
    set_ch(0, 8'd3, 8'd0);
    bus.en[0] = 1'b1; bus.oneshot[2] = 1'b1; bus.en[2] = 1'b1; set_ch(2, 8'd0, 8'd0);
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    check_val("r42_q", 64'(bus.q), 64'd0);
    check_val("r42_tc", 64'(bus.tc), 64'd0);
    check_val("r42_done", 64'(bus.done), 64'd0);
    check_val("r42_any", 64'(bus.any_tc), 64'd0);
    model_reset();
    #1 reset_n = 1'b1;
    idle();
    bus.en[0] = 1'b1;
    step();
    check_val("r42_resume", 64'(bus.q[7:0]), 64'd1);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        bus.clr[i]     = ($urandom_range(0, 31) == 0);
        bus.load[i]    = ($urandom_range(0, 15) == 0);
        bus.en[i]      = ($urandom_range(0, 3) != 0);
        bus.dir[i]     = ($urandom_range(0, 7) == 0) ? ~bus.dir[i] : bus.dir[i];
        bus.oneshot[i] = ($urandom_range(0, 15) == 0) ? ~bus.oneshot[i] : bus.oneshot[i];
        if ($urandom_range(0, 15) == 0) bus.limit[i*W +: W] = 8'($urandom_range(0, 12));
        bus.load_val[i*W +: W] = 8'($urandom_range(0, 15));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
